tt_um_seq_ctrl: RTL and testbench

//  Sequencer for the ternary weight store (28-bit row shift register, 7 rows) and the row-wise MAC.

---
 rtl/tt_seq_pkg.sv | 30 +++
 rtl/tt_modn_counter.sv | 25 ++
 rtl/tt_um_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_tt_um_seq_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_seq_pkg.sv
// rtl/tt_seq_pkg.sv - shared types and sizes for the ternary weight-store sequencer
package tt_seq_pkg;

   localparam int MAX_IN_LEN  = 14;
   localparam int MAX_OUT_LEN = 7;
   localparam int WIDTH       = 2;
   localparam int ROW_W       = WIDTH * MAX_IN_LEN;
   localparam int ROW_BITS    = $clog2(MAX_OUT_LEN);
   localparam int LOAD_CYCLES = 2 * MAX_OUT_LEN;
   localparam int BEAT_W      = $clog2(LOAD_CYCLES);
   localparam int COUNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2
   } state_t;

   // Beats 0..6 address the first half of rows 0..6, beats 7..13 the second half.
   function automatic logic [COUNT_W-1:0] beat_to_count(input logic [BEAT_W-1:0] beat);
      logic [BEAT_W-1:0] row;
      if (beat >= BEAT_W'(MAX_OUT_LEN)) begin
         row = beat - BEAT_W'(MAX_OUT_LEN);
         return {1'b1, row[ROW_BITS-1:0]};
      end else begin
         return {1'b0, beat[ROW_BITS-1:0]};
      end
   endfunction

endpackage

// File: rtl/tt_modn_counter.sv
// rtl/tt_modn_counter.sv - modulo-N up counter with synchronous clear and wrap flag
module tt_modn_counter #(
   parameter int N = 7,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] val,
   output logic         wrap
);

   assign wrap = inc && (val == W'(N - 1));

   // Count up on inc, returning to zero after N-1; clear has priority over inc.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         val <= '0;
      end else if (inc) begin
         val <= wrap ? '0 : val + W'(1);
      end
   end

endmodule

// File: rtl/tt_um_seq_ctrl.sv
// rtl/tt_um_seq_ctrl.sv - load/compute sequencer for the rotating ternary weight store
module tt_um_seq_ctrl
   import tt_seq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load_start,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                ena,
   output logic [COUNT_W-1:0]  count,
   output logic                load_busy,
   output logic                load_done,
   output logic                weights_valid,
   output logic                row_valid,
   output logic [ROW_BITS-1:0] row_idx,
   output logic                acc_clear,
   output logic                out_valid
);

   state_t              state;
   state_t              state_nxt;
   logic [ROW_BITS-1:0] rot_ptr;
   logic                rot_wrap;
   logic [BEAT_W-1:0]   beat;
   logic                beat_wrap;
   logic                pending_load;
   logic                load_exit;
   logic                compute_done;

   // The store rotates whenever it is not loading, so rot_ptr advances in
   // lock-step; after a burst row 0 sits at the head again.
   tt_modn_counter #(.N(MAX_OUT_LEN), .W(ROW_BITS)) u_rot_ptr (
      .clk  (clk),
      .rst  (rst),
      .clr  (load_exit),
      .inc  (state != LOAD),
      .val  (rot_ptr),
      .wrap (rot_wrap)
   );

   tt_modn_counter #(.N(LOAD_CYCLES), .W(BEAT_W)) u_beat (
      .clk  (clk),
      .rst  (rst),
      .clr  (state != LOAD),
      .inc  (state == LOAD),
      .val  (beat),
      .wrap (beat_wrap)
   );

   assign load_exit    = (state == LOAD) && beat_wrap;
   // Entry only happens with rot_ptr at the last row, so the wrap marks row MAX_OUT_LEN-1.
   assign compute_done = (state == COMPUTE) && rot_wrap;

   // A vector is taken only when row 0 arrives at the head on the next cycle.
   assign in_ready  = (state == IDLE) && weights_valid && !load_start && !pending_load &&
                      (rot_ptr == ROW_BITS'(MAX_OUT_LEN - 1));
   assign row_idx   = rot_ptr;
   assign acc_clear = row_valid && (rot_ptr == '0);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection and per-state store/MAC controls.
   always_comb begin
      state_nxt = state;
      ena       = 1'b0;
      count     = '0;
      load_busy = 1'b0;
      row_valid = 1'b0;
      case (state)
         IDLE: begin
            if (load_start || pending_load) begin
               state_nxt = LOAD;
            end else if (in_valid && in_ready) begin
               state_nxt = COMPUTE;
            end
         end
         LOAD: begin
            ena       = 1'b1;
            load_busy = 1'b1;
            count     = beat_to_count(beat);
            if (beat_wrap) begin
               state_nxt = IDLE;
            end
         end
         COMPUTE: begin
            row_valid = 1'b1;
            if (rot_wrap) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Remember load requests that arrive while busy; consumed when the burst starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_load <= 1'b0;
      end else if ((state != IDLE) && load_start) begin
         pending_load <= 1'b1;
      end else if ((state == IDLE) && (state_nxt == LOAD)) begin
         pending_load <= 1'b0;
      end
   end

   // Completion flags and single-cycle done pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         weights_valid <= 1'b0;
         load_done     <= 1'b0;
         out_valid     <= 1'b0;
      end else begin
         if (load_exit) begin
            weights_valid <= 1'b1;
         end
         load_done <= load_exit;
         out_valid <= compute_done;
      end
   end

endmodule

// File: tb/tb_tt_um_seq_ctrl.sv
// tb/tb_tt_um_seq_ctrl.sv - self-checking bench for tt_um_seq_ctrl with a rotating store model
module tb_tt_um_seq_ctrl;
   import tt_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_start = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       ena;
   logic [3:0] count;
   logic       load_busy;
   logic       load_done;
   logic       weights_valid;
   logic       row_valid;
   logic [2:0] row_idx;
   logic       acc_clear;
   logic       out_valid;

   int vectors = 0;
   int miscompares = 0;

   logic [27:0] wdata [7];
   logic [27:0] st [7];
   int          row_q [$];
   int          ov_q [$];
   int          mcyc = 0;
   int          mexp;
   int          mrow;
   logic        mdue;
   logic [27:0] mtmp;

   always #5 clk = ~clk;

   tt_um_seq_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .load_start    (load_start),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .ena           (ena),
      .count         (count),
      .load_busy     (load_busy),
      .load_done     (load_done),
      .weights_valid (weights_valid),
      .row_valid     (row_valid),
      .row_idx       (row_idx),
      .acc_clear     (acc_clear),
      .out_valid     (out_valid)
   );

   task automatic drive(input logic r, input logic ls, input logic iv);
      @(negedge clk);
      rst        = r;
      load_start = ls;
      in_valid   = iv;
      #1;
   endtask

   function automatic logic [14:0] outs();
      return {in_ready, ena, count, load_busy, load_done, weights_valid,
              row_valid, row_idx, acc_clear, out_valid};
   endfunction

   // Scoreboard and weight-store model: checks rows/out_valid, then applies the clock edge to the store.
   always begin
      @(negedge clk);
      #2;
      mcyc++;
      if (row_valid === 1'b1) begin
         vectors++;
         if (row_q.size() == 0) begin
            miscompares++;
            $display("FAIL row_unexpected: row_valid=1 row_idx=%0d, required no row", row_idx);
         end else begin
            mexp = row_q.pop_front();
            if (row_idx !== 3'(mexp) || acc_clear !== (mexp == 0) || st[0] !== wdata[mexp]) begin
               miscompares++;
               $display("FAIL sb_row: row_idx=%0d acc_clear=%0b uo_weights=%h, required %0d %0b %h",
                        row_idx, acc_clear, st[0], mexp, (mexp == 0), wdata[mexp]);
            end
         end
      end
      mdue = (ov_q.size() > 0) && (ov_q[0] == mcyc);
      if (mdue) void'(ov_q.pop_front());
      vectors++;
      if (out_valid !== mdue) begin
         miscompares++;
         $display("FAIL sb_out_valid: cycle %0d out_valid=%b, required %b", mcyc, out_valid, mdue);
      end
      if (rst === 1'b0 && in_valid === 1'b1 && in_ready === 1'b1) begin
         for (int r = 0; r < MAX_OUT_LEN; r++) row_q.push_back(r);
         ov_q.push_back(mcyc + 8);
      end
      if (rst === 1'b1) begin
         row_q.delete();
         ov_q.delete();
      end
      if (ena === 1'b1) begin
         mrow = int'(count[2:0]);
         if (mrow < MAX_OUT_LEN) begin
            if (count[3]) st[mrow][13:0] = wdata[mrow][13:0];
            else          st[mrow][27:14] = wdata[mrow][27:14];
         end
      end else begin
         mtmp = st[0];
         for (int i = 0; i < MAX_OUT_LEN - 1; i++) st[i] = st[i + 1];
         st[MAX_OUT_LEN - 1] = mtmp;
      end
   end

   task automatic test_reset();
      drive(1, 0, 0);
      vectors++;
      if (outs() !== 15'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, required 0", outs());
      end
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 1);
         vectors++;
         if (ena !== 1'b0 || in_ready !== 1'b0 || weights_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_weights: cycle %0d ena=%b in_ready=%b wv=%b, required 0 0 0",
                     i, ena, in_ready, weights_valid);
         end
      end
   endtask

   task automatic test_load();
      logic [3:0] expc;
      for (int i = 0; i < MAX_OUT_LEN; i++) wdata[i] = 28'($urandom);
      drive(0, 1, 0);
      vectors++;
      if (ena !== 1'b0 || load_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL load_request_cycle: ena=%b busy=%b, required 0 0", ena, load_busy);
      end
      for (int b = 0; b < LOAD_CYCLES; b++) begin
         drive(0, 0, 0);
         expc = (b < 7) ? 4'(b) : 4'(b + 1);
         vectors++;
         if (ena !== 1'b1 || load_busy !== 1'b1 || count !== expc || load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL load_beat: beat %0d ena=%b busy=%b count=%h done=%b, required 1 1 %h 0",
                     b, ena, load_busy, count, load_done, expc);
         end
      end
      drive(0, 0, 0);
      vectors++;
      if (load_done !== 1'b1 || ena !== 1'b0 || count !== 4'd0 || weights_valid !== 1'b1 ||
          row_idx !== 3'd0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL load_done: done=%b ena=%b count=%h wv=%b row_idx=%0d ready=%b, required 1 0 0 1 0 0",
                  load_done, ena, count, weights_valid, row_idx, in_ready);
      end
      for (int k = 1; k <= 6; k++) begin
         drive(0, 0, 0);
         vectors++;
         if (in_ready !== (k == 6) || load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_load: +%0d in_ready=%b done=%b, required %b 0",
                     k, in_ready, load_done, (k == 6));
         end
      end
   endtask

   task automatic test_compute();
      logic found;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         drive(0, 0, 1);
         if (in_ready === 1'b1) found = 1'b1;
      end
      vectors++;
      if (!found || row_idx !== 3'd6) begin
         miscompares++;
         $display("FAIL accept: found=%b row_idx=%0d, required 1 6", found, row_idx);
      end
      for (int r = 0; r < MAX_OUT_LEN; r++) begin
         drive(0, 0, 0);
         vectors++;
         if (row_valid !== 1'b1 || row_idx !== 3'(r) || acc_clear !== (r == 0) || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL compute_row: row_valid=%b row_idx=%0d acc_clear=%b ready=%b, required 1 %0d %b 0",
                     row_valid, row_idx, acc_clear, in_ready, r, (r == 0));
         end
      end
      drive(0, 0, 0);
      vectors++;
      if (out_valid !== 1'b1 || row_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL compute_done: out_valid=%b row_valid=%b, required 1 0", out_valid, row_valid);
      end
   endtask

   task automatic test_pending_load();
      logic found;
      logic [3:0] expc;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         drive(0, 0, 1);
         if (in_ready === 1'b1) found = 1'b1;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL pend_accept: found=%b, required 1", found);
      end
      for (int r = 0; r < MAX_OUT_LEN; r++) begin
         drive(0, r == 2, 0);
         vectors++;
         if (row_valid !== 1'b1 || row_idx !== 3'(r) || ena !== 1'b0) begin
            miscompares++;
            $display("FAIL pend_row: row_valid=%b row_idx=%0d ena=%b, required 1 %0d 0",
                     row_valid, row_idx, ena, r);
         end
      end
      drive(0, 0, 0);
      for (int i = 0; i < MAX_OUT_LEN; i++) wdata[i] = 28'($urandom);
      vectors++;
      if (out_valid !== 1'b1 || ena !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL pend_out: out_valid=%b ena=%b ready=%b, required 1 0 0", out_valid, ena, in_ready);
      end
      for (int b = 0; b < LOAD_CYCLES; b++) begin
         drive(0, 0, 0);
         expc = (b < 7) ? 4'(b) : 4'(b + 1);
         vectors++;
         if (ena !== 1'b1 || count !== expc) begin
            miscompares++;
            $display("FAIL pend_beat: beat %0d ena=%b count=%h, required 1 %h", b, ena, count, expc);
         end
      end
      drive(0, 0, 0);
      vectors++;
      if (load_done !== 1'b1 || ena !== 1'b0) begin
         miscompares++;
         $display("FAIL pend_done: done=%b ena=%b, required 1 0", load_done, ena);
      end
   endtask

   task automatic test_load_vs_vector();
      logic found;
      logic [3:0] expc;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         drive(0, 0, 0);
         if (row_idx === 3'd5) found = 1'b1;
      end
      for (int i = 0; i < MAX_OUT_LEN; i++) wdata[i] = 28'($urandom);
      drive(0, 1, 1);
      vectors++;
      if (!found || in_ready !== 1'b0 || ena !== 1'b0 || row_idx !== 3'd6) begin
         miscompares++;
         $display("FAIL collide_idle: found=%b ready=%b ena=%b row_idx=%0d, required 1 0 0 6",
                  found, in_ready, ena, row_idx);
      end
      for (int pass = 0; pass < 2; pass++) begin
         for (int b = 0; b < LOAD_CYCLES; b++) begin
            drive(0, (pass == 0) && (b == 3), 1);
            expc = (b < 7) ? 4'(b) : 4'(b + 1);
            vectors++;
            if (ena !== 1'b1 || count !== expc || row_valid !== 1'b0 || in_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL collide_beat: pass %0d beat %0d ena=%b count=%h row_valid=%b ready=%b, required 1 %h 0 0",
                        pass, b, ena, count, row_valid, in_ready, expc);
            end
         end
         drive(0, 0, 0);
         vectors++;
         if (load_done !== 1'b1 || ena !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_done: pass %0d done=%b ena=%b ready=%b, required 1 0 0",
                     pass, load_done, ena, in_ready);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic found;
      drive(0, 1, 0);
      for (int b = 0; b < 5; b++) drive(0, 0, 0);
      drive(1, 0, 0);
      vectors++;
      if (count !== 4'd5 || ena !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_beat5_pre: count=%h ena=%b, required 5 1", count, ena);
      end
      drive(0, 0, 0);
      vectors++;
      if (outs() !== 15'd0) begin
         miscompares++;
         $display("FAIL rst_mid_load: got %h, required 0", outs());
      end
      drive(0, 1, 0);
      for (int b = 0; b < LOAD_CYCLES; b++) drive(0, 0, 0);
      drive(0, 0, 0);
      vectors++;
      if (load_done !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_reload_done: done=%b, required 1", load_done);
      end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         drive(0, 0, 1);
         if (in_ready === 1'b1) found = 1'b1;
      end
      for (int r = 0; r < 3; r++) drive(0, 0, 0);
      drive(1, 0, 0);
      vectors++;
      if (!found || row_valid !== 1'b1 || row_idx !== 3'd3) begin
         miscompares++;
         $display("FAIL rst_row3_pre: found=%b row_valid=%b row_idx=%0d, required 1 1 3",
                  found, row_valid, row_idx);
      end
      drive(0, 0, 1);
      vectors++;
      if (outs() !== 15'd0) begin
         miscompares++;
         $display("FAIL rst_mid_compute: got %h, required 0", outs());
      end
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 1);
         vectors++;
         if (in_ready !== 1'b0 || weights_valid !== 1'b0 || row_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after_idle: ready=%b wv=%b row_valid=%b, required 0 0 0",
                     in_ready, weights_valid, row_valid);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < MAX_OUT_LEN; i++) begin
         st[i]    = '0;
         wdata[i] = '0;
      end
      test_reset();
      test_load();
      test_compute();
      test_pending_load();
      test_compute();
      test_load_vs_vector();
      test_compute();
      test_reset_mid();
      drive(0, 0, 0);
      drive(0, 0, 0);
      vectors++;
      if (row_q.size() != 0 || ov_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: rows=%0d out_valids=%0d, required 0 0", row_q.size(), ov_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
